// File: rtl/alu_uart_pkg.sv
// Shared types and constants for the ALU result serial transmitter.
// The frame is header, result, flags, checksum, each sent as one 8N1 byte.
package alu_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int         FRAME_BYTES    = 4;
    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam int         OVF_BIT        = 7;
    localparam int         ZERO_BIT       = 6;

    function automatic logic [7:0] flag_byte(input logic ovf, input logic zr);
        logic [7:0] f;
        f           = 8'h00;
        f[OVF_BIT]  = ovf;
        f[ZERO_BIT] = zr;
        return f;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer. A start request during the final stop-bit
// cycle chains the next byte with no gap; done only pulses when the line goes idle.
module uart_tx_byte
    import alu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       last
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (baud_cnt == CNT_MAX);
    assign busy    = (state != IDLE);
    assign last    = (state == STOP) && bit_end;

    always_comb begin
        state_nxt = state;
        tx        = 1'b1;
        case (state)
            IDLE:  if (start) state_nxt = START;
            START: begin
                tx = 1'b0;
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                tx = shreg[0];
                if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
            end
            STOP:  if (bit_end) state_nxt = start ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= last && !start;
            // Counter restarts on every state change and at each bit boundary.
            if (state_nxt != state || bit_end || state == IDLE)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;
            if ((state == IDLE || last) && start)
                shreg <= data;
            else if (state == DATA && bit_end)
                shreg <= shreg >> 1;
            if (state != DATA)
                bit_idx <= 3'd0;
            else if (bit_end)
                bit_idx <= bit_idx + 3'd1;
        end
    end

endmodule

// File: rtl/alu_result_uart_tx.sv
// Sends {header, result, flags, checksum} over UART on each accepted send,
// sequencing the four bytes back-to-back through uart_tx_byte.
module alu_result_uart_tx
    import alu_uart_pkg::*;
#(
    parameter int         DATA_WIDTH   = 8,
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] HEADER_BYTE  = HEADER_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  send,
    input  logic [DATA_WIDTH-1:0] result,
    input  logic                  overflow,
    input  logic                  zero,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    logic [7:0] result_q, flags_q, byte_data;
    logic [1:0] byte_idx, byte_sel;
    logic       accept, more, byte_last, byte_start;

    // Requests are only taken while the serializer is idle, including the done cycle.
    assign accept     = send && !busy;
    assign more       = byte_last && (byte_idx != 2'(FRAME_BYTES - 1));
    assign byte_start = accept || more;
    assign byte_sel   = accept ? 2'd0 : byte_idx + 2'd1;

    always_comb begin
        byte_data = HEADER_BYTE;
        case (byte_sel)
            2'd1:    byte_data = result_q;
            2'd2:    byte_data = flags_q;
            2'd3:    byte_data = HEADER_BYTE ^ result_q ^ flags_q;
            default: byte_data = HEADER_BYTE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= 8'h00;
            flags_q  <= 8'h00;
            byte_idx <= 2'd0;
        end else if (accept) begin
            result_q <= result;
            flags_q  <= flag_byte(overflow, zero);
            byte_idx <= 2'd0;
        end else if (more) begin
            byte_idx <= byte_idx + 2'd1;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (byte_start),
        .data   (byte_data),
        .tx     (tx),
        .busy   (busy),
        .done   (done),
        .last   (byte_last)
    );

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Bench for alu_result_uart_tx: table of frames, cycle-accurate busy/done model,
// UART line decoder feeding a byte scoreboard, plus directed corner sequences.
module tb_alu_result_uart_tx;

    localparam int C         = 4;
    localparam int FRAME_CYC = 40 * C;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       send;
    logic [7:0] result;
    logic       overflow, zero;
    logic       tx, busy, done;

    int n_vec = 0;
    int n_err = 0;

    alu_result_uart_tx #(
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(C),
        .HEADER_BYTE (8'hA5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .send    (send),
        .result  (result),
        .overflow(overflow),
        .zero    (zero),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: acceptance, busy/done timing and expected bytes.
    logic [7:0] exp_q[$];
    logic [7:0] rx_hist[$];
    int         mdl_left = 0;
    logic       mdl_done = 1'b0;
    logic       chk_on = 1'b0;
    int         done_cnt = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdl_left <= 0;
            mdl_done <= 1'b0;
            exp_q.delete();
        end else begin
            mdl_done <= (mdl_left == 1);
            if (mdl_left != 0) begin
                mdl_left <= mdl_left - 1;
            end else if (send) begin
                mdl_left <= FRAME_CYC;
                exp_q.push_back(8'hA5);
                exp_q.push_back(result);
                exp_q.push_back({overflow, zero, 6'b0});
                exp_q.push_back(8'hA5 ^ result ^ {overflow, zero, 6'b0});
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && chk_on) begin
            chk("busy", busy, mdl_left != 0);
            chk("done", done, mdl_done);
            if (mdl_left == 0)         chk("tx_idle", tx, 1);
            if (mdl_left == FRAME_CYC) chk("tx_start", tx, 0);
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    // Line decoder: samples mid-bit, sample 0 is the first low sample.
    logic       rx_on = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;

    always @(negedge clk) begin
        if (!reset_n) begin
            rx_on  <= 1'b0;
            rx_cnt <= 0;
        end else if (!rx_on) begin
            if (tx == 1'b0) begin
                rx_on  <= 1'b1;
                rx_cnt <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt % C == C / 2) begin
                if (rx_cnt / C == 0) begin
                    chk("start_bit", tx, 0);
                end else if (rx_cnt / C <= 8) begin
                    rx_sh <= {tx, rx_sh[7:1]};
                end else begin
                    chk("stop_bit", tx, 1);
                    rx_on <= 1'b0;
                    rx_hist.push_back(rx_sh);
                    if (exp_q.size() == 0)
                        chk("unexpected_byte", 32'(rx_sh), 32'hFFFF_FFFF);
                    else
                        chk("sb_byte", rx_sh, exp_q.pop_front());
                end
            end
        end
    end

    task automatic check_frame(input string nm, input logic [31:0] exp);
        chk({nm, "_nbytes"}, rx_hist.size(), 4);
        if (rx_hist.size() >= 4) begin
            chk({nm, "_b0"}, rx_hist[0], exp[31:24]);
            chk({nm, "_b1"}, rx_hist[1], exp[23:16]);
            chk({nm, "_b2"}, rx_hist[2], exp[15:8]);
            chk({nm, "_b3"}, rx_hist[3], exp[7:0]);
        end
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 1;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) chk("done_timeout", 0, 1);
    endtask

    typedef struct {
        logic [7:0]  res;
        logic        ovf;
        logic        zr;
        logic [31:0] bytes;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d0;
        vecs[0] = '{8'h3C, 1'b1, 1'b0, 32'hA53C_8019};
        vecs[1] = '{8'h00, 1'b0, 1'b1, 32'hA500_40E5};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 32'hA5FF_C09A};
        vecs[3] = '{8'h5A, 1'b0, 1'b0, 32'hA55A_00FF};

        reset_n = 1'b0; send = 1'b0; result = 8'h00; overflow = 1'b0; zero = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk_on  = 1'b1;
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (100) begin
            @(negedge clk);
            chk("idle_tx", tx, 1);
        end

        foreach (vecs[i]) begin
            rx_hist.delete();
            result = vecs[i].res; overflow = vecs[i].ovf; zero = vecs[i].zr;
            d0 = done_cnt;
            send = 1'b1;
            @(negedge clk);
            send = 1'b0;
            chk("tx_fall", tx, 0);
            chk("busy_rise", busy, 1);
            wait_done(400, n);
            chk("frame_len", n, FRAME_CYC + 1);
            chk("done_busy_low", busy, 0);
            @(negedge clk);
            chk("done_single", done, 0);
            check_frame("vec", vecs[i].bytes);
            chk("done_count", done_cnt - d0, 1);
            repeat (5) @(negedge clk);
        end

        // Input changes and a second send mid-frame must not disturb the frame.
        rx_hist.delete();
        d0 = done_cnt;
        result = 8'h3C; overflow = 1'b1; zero = 1'b0;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (49) @(negedge clk);
        result = 8'hFF; overflow = 1'b0; zero = 1'b1;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        wait_done(400, n);
        repeat (60) @(negedge clk);
        check_frame("stable", 32'hA53C_8019);
        chk("stable_done_count", done_cnt - d0, 1);
        chk("stable_no_second", busy, 0);

        // Reset mid-frame, then a fresh frame with send already high at release.
        rx_hist.delete();
        result = 8'h3C; overflow = 1'b1; zero = 1'b0;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (69) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rx_hist.delete();
        result = 8'h00; overflow = 1'b0; zero = 1'b1;
        send = 1'b1;
        reset_n = 1'b1;
        @(negedge clk);
        send = 1'b0;
        chk("rst_restart_fall", tx, 0);
        wait_done(400, n);
        chk("rst_restart_len", n, FRAME_CYC + 1);
        @(negedge clk);
        check_frame("restart", 32'hA500_40E5);

        // Send held high: frames separated by one idle cycle, inputs churning.
        repeat (5) @(negedge clk);
        rx_hist.delete();
        d0 = done_cnt;
        send = 1'b1;
        repeat (400) begin
            @(negedge clk);
            result   = 8'($urandom);
            overflow = 1'($urandom);
            zero     = 1'($urandom);
        end
        send = 1'b0;
        wait_done(300, n);
        repeat (5) @(negedge clk);
        chk("b2b_frames", done_cnt - d0, 3);
        chk("b2b_bytes", rx_hist.size(), 12);
        for (int f = 0; f < 3; f++) begin
            if (rx_hist.size() >= 4 * f + 4) begin
                chk("b2b_header", rx_hist[4*f], 8'hA5);
                chk("b2b_checksum", rx_hist[4*f+3],
                    rx_hist[4*f] ^ rx_hist[4*f+1] ^ rx_hist[4*f+2]);
            end
        end
        chk("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_result_uart_tx.md
Name: alu_result_uart_tx

Overview:
- Serial transmitter that sends the ALU result and its status flags to a host PC over the board's USB-UART TX line.
- This is the outbound direction of the switch/button operand path: operands enter by hand, results leave over serial.
- Sits beside the 7-segment display controller in the top level. It is driven by the ALU result bus, the Overflow and Zero flags, and a one-cycle send request.
- Each request produces a fixed 4-byte frame in 8N1 format: header, result, flags, checksum.

Parameters:
- DATA_WIDTH, 8: width of the result operand. Only 8 is supported; the frame layout is fixed to 8 bits.
- CLKS_PER_BIT, 868: clock cycles per UART bit. 868 gives 115200 baud at 100 MHz. Legal range is 2 to 65535.
- HEADER_BYTE, 8'hA5: first byte of every frame.

Ports:
- clk  in  1  system clock (100 MHz on board)
- reset_n  in  1  asynchronous active-low reset
- send  in  1  one-cycle request to transmit a frame
- result  in  DATA_WIDTH  ALU result
- overflow  in  1  ALU Overflow flag
- zero  in  1  ALU Zero flag
- tx  out  1  UART serial output; idle level is high
- busy  out  1  high while a frame is in progress
- done  out  1  one-cycle pulse when a frame completes

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: tx=1, busy=0, done=0, FSM=IDLE, all counters 0.
- reset_n low mid-frame: tx returns high immediately (asynchronously). The frame is abandoned and never resumed.
- Capture: when send=1 in IDLE, the block latches result, overflow and zero on that edge. Later changes on the inputs do not affect the frame in flight.
- Frame bytes, in order:
  - B0 = HEADER_BYTE
  - B1 = result
  - B2 = {overflow, zero, 6'b0}
  - B3 = B0 ^ B1 ^ B2
- Each byte is 8N1: start bit (0), data bits LSB first, stop bit (1). Every bit is held exactly CLKS_PER_BIT cycles.
- Bytes are sent back-to-back. The start bit of byte N+1 begins on the cycle after byte N's stop bit ends.
- Latency: tx goes low on the clock edge after send is sampled. busy rises on that same edge.
- Frame length is exactly 40*CLKS_PER_BIT cycles from tx falling to the end of B3's stop bit.
- FSM states:
  - IDLE: send goes to START (byte_idx=0).
  - START: after CLKS_PER_BIT cycles, go to DATA (bit_idx=0).
  - DATA: after CLKS_PER_BIT cycles per bit, move to the next bit. After bit 7 finishes, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, go to START with byte_idx+1 if byte_idx<3. Otherwise go to IDLE.
- Completion: entering IDLE from STOP drives done=1 for one cycle, with busy=0 and tx=1 in that cycle.
- send while busy=1 is ignored. It is neither queued nor allowed to disturb the frame.
- send in the same cycle as done (already in IDLE) is accepted, and a new frame starts on the next edge.
- send held high continuously produces back-to-back frames, each separated by exactly one idle cycle.
- The baud counter counts 0..CLKS_PER_BIT-1, wraps, and is cleared on every state change.
- The bit index counts 0..7; the byte index counts 0..3.

Decomposition:
- Shared package alu_uart_pkg holds:
  - the FSM state encoding (IDLE, START, DATA, STOP), 2 bits
  - FRAME_BYTES=4
  - HEADER_BYTE default
  - flag bit positions (OVF_BIT=7, ZERO_BIT=6)
- Sub-module uart_tx_byte: a single-byte 8N1 serializer with start/busy/done handshake.
  - This block's top FSM sequences the 4 bytes through it and computes the checksum.
  - The top level may reuse it later for other status output.

Test Plan (bench uses CLKS_PER_BIT=4):
- Reset check: reset_n low for 3 cycles, then released -> tx=1, busy=0, done=0. tx stays high for 100 cycles with send=0.
- Basic frame: result=8'h3C, overflow=1, zero=0, single send pulse.
  - tx falls 1 cycle later.
  - Decoded bytes are A5, 3C, 80, 19.
  - Each bit lasts 4 cycles; the frame lasts 160 cycles.
  - done pulses once, coincident with busy falling.
- Zero-result frame: result=8'h00, overflow=0, zero=1 -> bytes A5, 00, 40, E5.
- Input stability and ignored request:
  - Change result to 8'hFF and pulse send at cycle 50 of an in-flight frame with result=8'h3C.
  - Frame still carries 3C; no second frame follows; exactly one done pulse.
- Reset mid-frame:
  - Assert reset_n low at cycle 70 -> tx=1, busy=0 immediately.
  - After release with send=1, a complete fresh frame starts from B0=A5.
- Back-to-back: send held high for 400 cycles -> consecutive frames separated by exactly one tx-high idle cycle. Every checksum is correct.
